// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and the serial adder FSM state encoding
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_SIX = 4'd6;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD adder with >9 decimal correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] z;
  // binary sum, then add six when it exceeds nine (invalid digits follow the same rule)
  always_comb begin
    z = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    co = z > 5'd9;
    s = co ? z[3:0] + BCD_SIX : z[3:0];
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial BCD add/subtract, LSD first, one digit per clock
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            op_sub,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   a_bcd,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   b_bcd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   sum_bcd,
  output logic                            carry_out,
  output logic                            err_digit,
  output logic                            busy
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, b_nine;
  logic carry_q, carry_d, err_q, err_d, err_in, dig_co;
  logic [3:0] dig_s;
  bcd_digit_add u_add (
    .a (a_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W]),
    .b (b_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W]),
    .ci(carry_q),
    .s (dig_s),
    .co(dig_co)
  );
  // per-digit 9's complement of B and detection of any non-decimal input digit
  always_comb begin
    b_nine = '0;
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b_nine[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE - b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      err_in = err_in | (a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_NINE)
                      | (b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_NINE);
    end
  end
  // next-state: latch on accept, one digit step per RUN cycle, release on consumer handshake
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d = ST_RUN;
        a_d = a_bcd;
        b_d = op_sub ? b_nine : b_bcd;
        carry_d = op_sub;
        idx_d = '0;
        err_d = err_in;
      end
      ST_RUN: begin
        sum_d[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_s;
        carry_d = dig_co;
        idx_d = idx_q + IW'(1);
        state_d = idx_q == IW'(DIGITS - 1) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers; reset discards any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy = state_q != ST_IDLE;
  assign sum_bcd = sum_q;
  assign carry_out = carry_q;
  assign err_digit = err_q;
endmodule
